router_op_lut_event_pacer: RTL and testbench

- Sits between op_lut_process_sm and router_op_lut_regs_cntr.
- Takes single-cycle event pulses from the process SM and re-emits each event on its own update line. Pulses on any one line are spaced at least MIN_UPDATE_INTERVAL clocks apart, which is the counter block's requirement.
- Back-to-back events are queued in a small per-event pending counter, so bursts are not lost.
- If a pending counter saturates, further events on that line are dropped and a sticky overflow flag is set.

---
 rtl/router_op_lut_event_pacer_pkg.sv | 41 ++++
 rtl/router_op_lut_event_pacer_chan.sv | 101 ++++++++++
 rtl/router_op_lut_event_pacer.sv | 58 +++++
 tb/tb_router_op_lut_event_pacer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_op_lut_event_pacer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_op_lut_event_pacer_pkg
// Description : Shared constants for the op-LUT event pacer: the
//               ROUTER_OP_LUT_* event bit indices (same numbering as the
//               counter block's updates bus), the default line count and a
//               ceiling-log2 helper used to size the per-line spacing timer.
// Revision    : 1.0 - initial release
// ============================================================================
package router_op_lut_event_pacer_pkg;

    // Event bit positions on events_in / updates_out / overflow.
    localparam int ROUTER_OP_LUT_ARP_PACKETS    = 0;
    localparam int ROUTER_OP_LUT_IP_PACKETS     = 1;
    localparam int ROUTER_OP_LUT_OPTION_PACKETS = 2;
    localparam int ROUTER_OP_LUT_BAD_OPTS_VER   = 3;
    localparam int ROUTER_OP_LUT_BAD_CHKSUMS    = 4;
    localparam int ROUTER_OP_LUT_BAD_TTLS       = 5;
    localparam int ROUTER_OP_LUT_NON_IP_RCVD    = 6;
    localparam int ROUTER_OP_LUT_ARP_MISSES     = 7;
    localparam int ROUTER_OP_LUT_LPM_MISSES     = 8;
    localparam int ROUTER_OP_LUT_FILTERED_PKTS  = 9;

    localparam int ROUTER_OP_LUT_NUM_EVENTS     = 10;

    // Ceiling log2 with a floor of 1, so a counter sized from it always has
    // at least one bit even when the value to hold is 0 or 1.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : router_op_lut_event_pacer_pkg
`default_nettype wire

// File: rtl/router_op_lut_event_pacer_chan.sv
`default_nettype none
// ============================================================================
// Module      : router_op_lut_event_pacer_chan
// Description : One event line of the pacer. Re-emits input event pulses as
//               registered update pulses spaced at least MIN_UPDATE_INTERVAL
//               clocks apart, queueing bursts in a saturating pending counter
//               and flagging (sticky) any event lost to saturation.
// Ports       : clk, reset (async, active-low)
//               event_in      - single-cycle event pulse
//               overflow_clr  - synchronous clear of the overflow flag
//               update_out    - registered paced update pulse
//               overflow      - sticky "event dropped" flag
//               pending       - pending counter is non-zero
// Revision    : 1.0 - initial release
// ============================================================================
module router_op_lut_event_pacer_chan
    import router_op_lut_event_pacer_pkg::*;
#(
    parameter int MIN_UPDATE_INTERVAL = 8,
    parameter int PEND_WIDTH          = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic event_in,
    input  logic overflow_clr,
    output logic update_out,
    output logic overflow,
    output logic pending
);

    localparam int                      c_TIMER_W      = clog2_min1(MIN_UPDATE_INTERVAL);
    localparam logic [c_TIMER_W-1:0]    c_TIMER_RELOAD = c_TIMER_W'(MIN_UPDATE_INTERVAL - 1);
    localparam logic [c_TIMER_W-1:0]    c_TIMER_ONE    = c_TIMER_W'(1);
    localparam logic [PEND_WIDTH-1:0]   c_PEND_MAX     = '1;
    localparam logic [PEND_WIDTH-1:0]   c_PEND_ONE     = PEND_WIDTH'(1);

    logic [PEND_WIDTH-1:0] r_pend;
    logic [c_TIMER_W-1:0]  r_timer;
    logic                  r_ovf;
    logic                  r_update;

    logic                  w_timer_idle;
    logic                  w_emit;
    logic                  w_pend_full;
    logic                  w_drop;
    logic [PEND_WIDTH-1:0] w_pend_nxt;
    logic [c_TIMER_W-1:0]  w_timer_nxt;

    always_comb begin
        w_timer_idle = (r_timer == '0);
        // A fresh event with an empty queue and an idle timer emits directly,
        // so the queue is bypassed and latency is a single cycle.
        w_emit       = w_timer_idle && ((r_pend != '0) || event_in);
        w_pend_full  = (r_pend == c_PEND_MAX);
        // An event that cannot emit and finds the queue full is lost.
        w_drop       = event_in && !w_emit && w_pend_full;

        w_pend_nxt = r_pend;
        if (event_in && !w_emit && !w_pend_full) begin
            w_pend_nxt = r_pend + c_PEND_ONE;
        end else if (!event_in && w_emit) begin
            // Emitting without a new event implies r_pend != 0 (the emit
            // was driven by the backlog), so this cannot underflow.
            w_pend_nxt = r_pend - c_PEND_ONE;
        end
        // event_in && w_emit: either a bypass (pend stays 0) or one consumed
        // and one added (pend unchanged) - both leave r_pend as is.

        w_timer_nxt = r_timer;
        if (w_emit) begin
            w_timer_nxt = c_TIMER_RELOAD;
        end else if (!w_timer_idle) begin
            w_timer_nxt = r_timer - c_TIMER_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend   <= '0;
            r_timer  <= '0;
            r_ovf    <= 1'b0;
            r_update <= 1'b0;
        end else begin
            r_pend   <= w_pend_nxt;
            r_timer  <= w_timer_nxt;
            r_update <= w_emit;
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (overflow_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign update_out = r_update;
    assign overflow   = r_ovf;
    assign pending    = (r_pend != '0);

endmodule : router_op_lut_event_pacer_chan
`default_nettype wire

// File: rtl/router_op_lut_event_pacer.sv
`default_nettype none
// ============================================================================
// Module      : router_op_lut_event_pacer
// Description : Paces event pulses from op_lut_process_sm onto the counter
//               block's updates bus. Each line is independent: pulses on one
//               line are at least MIN_UPDATE_INTERVAL clocks apart, bursts
//               are queued per line, and saturation drops are flagged.
// Ports       : clk, reset (async, active-low)
//               events_in    [NUM_EVENTS] - event pulses, any combination
//               updates_out  [NUM_EVENTS] - registered paced update pulses
//               overflow     [NUM_EVENTS] - sticky per-line drop flags
//               overflow_clr              - synchronous clear of overflow
//               pending_any               - any line has queued events
// Revision    : 1.0 - initial release
// ============================================================================
module router_op_lut_event_pacer
    import router_op_lut_event_pacer_pkg::*;
#(
    parameter int NUM_EVENTS          = ROUTER_OP_LUT_NUM_EVENTS,
    parameter int MIN_UPDATE_INTERVAL = 8,
    parameter int PEND_WIDTH          = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] events_in,
    output logic [NUM_EVENTS-1:0] updates_out,
    output logic [NUM_EVENTS-1:0] overflow,
    input  logic                  overflow_clr,
    output logic                  pending_any
);

    logic [NUM_EVENTS-1:0] w_pending;

    // No arbitration between lines: every line has its own pacing state and
    // may emit in the same cycle as any other.
    generate
        for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_chan
            router_op_lut_event_pacer_chan #(
                .MIN_UPDATE_INTERVAL (MIN_UPDATE_INTERVAL),
                .PEND_WIDTH          (PEND_WIDTH)
            ) u_chan (
                .clk          (clk),
                .reset        (reset),
                .event_in     (events_in[gi]),
                .overflow_clr (overflow_clr),
                .update_out   (updates_out[gi]),
                .overflow     (overflow[gi]),
                .pending      (w_pending[gi])
            );
        end
    endgenerate

    // Reduced straight from the pending-counter registers, so it tracks the
    // queue state with no added cycle.
    assign pending_any = |w_pending;

endmodule : router_op_lut_event_pacer
`default_nettype wire

// File: tb/tb_router_op_lut_event_pacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_op_lut_event_pacer
// Description : Directed self-checking bench for router_op_lut_event_pacer
//               with default parameters (10 lines, interval 8, 4-bit queue).
//               Cycle index k counts the clock edges of a scenario; outputs
//               are sampled 1 time unit after edge k.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_op_lut_event_pacer;

    localparam int NE = 10;

    logic          clk;
    logic          reset;
    logic [NE-1:0] events_in;
    logic [NE-1:0] updates_out;
    logic [NE-1:0] overflow;
    logic          overflow_clr;
    logic          pending_any;

    int n_compared;
    int n_mismatched;

    router_op_lut_event_pacer #(
        .NUM_EVENTS          (NE),
        .MIN_UPDATE_INTERVAL (8),
        .PEND_WIDTH          (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .events_in    (events_in),
        .updates_out  (updates_out),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .pending_any  (pending_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply ev for one edge, then sample just after that edge.
    task automatic step(input logic [NE-1:0] ev);
        events_in = ev;
        @(posedge clk);
        #1;
        events_in = '0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        events_in    = '1;
        overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_compared++;
        if (updates_out !== '0) begin
            n_mismatched++;
            $display("FAIL reset_updates: got %h expected %h", updates_out, 10'h000);
        end
        n_compared++;
        if (overflow !== '0) begin
            n_mismatched++;
            $display("FAIL reset_overflow: got %h expected %h", overflow, 10'h000);
        end
        n_compared++;
        if (pending_any !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_pending_any: got %b expected 0", pending_any);
        end
        events_in = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Single event on an idle line: pulse on the very next cycle only.
    task automatic test_single_pulse();
        for (int k = 0; k < 4; k++) begin
            step((k == 0) ? 10'h008 : 10'h000);
            n_compared++;
            if (updates_out !== ((k == 0) ? 10'h008 : 10'h000) || pending_any !== 1'b0) begin
                n_mismatched++;
                $display("FAIL single_pulse k=%0d: got upd=%h pa=%b expected upd=%h pa=0",
                         k, updates_out, pending_any, (k == 0) ? 10'h008 : 10'h000);
            end
        end
    endtask

    // Bit 0 high for k=0..4: emits at k=0,8,16,24,32; queue 1..4 then drains,
    // reaching 0 at the k=32 emit.
    task automatic test_back_to_back();
        int pulses;
        logic exp_upd, exp_pa;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            step((k < 5) ? 10'h001 : 10'h000);
            exp_upd = (k % 8 == 0) && (k <= 32);
            exp_pa  = (k >= 1) && (k <= 31);
            if (updates_out[0]) pulses++;
            n_compared++;
            if (updates_out !== {9'b0, exp_upd} || pending_any !== exp_pa || overflow !== '0) begin
                n_mismatched++;
                $display("FAIL back_to_back k=%0d: got upd=%h pa=%b ovf=%h expected upd=%h pa=%b ovf=000",
                         k, updates_out, pending_any, overflow, {9'b0, exp_upd}, exp_pa);
            end
        end
        n_compared++;
        if (pulses != 5) begin
            n_mismatched++;
            $display("FAIL back_to_back_count: got %0d expected 5", pulses);
        end
    endtask

    // Bit 7 high for k=0..19. Emits at k=0 and k=16 coincide with events, so
    // the queue reaches 15 at k=17 and the events at k=18,19 are dropped:
    // 18 accepted events -> 18 pulses at k=0,8,...,136; queue empty at k=136.
    task automatic test_saturation();
        int pulses;
        logic exp_upd, exp_pa, exp_ovf;
        pulses = 0;
        for (int k = 0; k < 150; k++) begin
            step((k < 20) ? 10'h080 : 10'h000);
            exp_upd = (k % 8 == 0) && (k <= 136);
            exp_pa  = (k >= 1) && (k <= 135);
            exp_ovf = (k >= 18);
            if (updates_out[7]) pulses++;
            n_compared++;
            if (updates_out !== (NE'(exp_upd) << 7) || pending_any !== exp_pa ||
                overflow !== (NE'(exp_ovf) << 7)) begin
                n_mismatched++;
                $display("FAIL saturation k=%0d: got upd=%h pa=%b ovf=%h expected upd=%h pa=%b ovf=%h",
                         k, updates_out, pending_any, overflow,
                         NE'(exp_upd) << 7, exp_pa, NE'(exp_ovf) << 7);
            end
        end
        n_compared++;
        if (pulses != 18) begin
            n_mismatched++;
            $display("FAIL saturation_count: got %0d expected 18", pulses);
        end
        overflow_clr = 1'b1;
        step(10'h000);
        overflow_clr = 1'b0;
        n_compared++;
        if (overflow !== '0) begin
            n_mismatched++;
            $display("FAIL overflow_clr: got %h expected %h", overflow, 10'h000);
        end
    endtask

    // Bit 2 events at k=0,1,2 build pend=2; another event at the k=8 emit
    // edge keeps pend at 2. Four events -> pulses at k=0,8,16,24.
    task automatic test_emit_edge_event();
        int pulses;
        logic exp_upd, exp_pa;
        pulses = 0;
        for (int k = 0; k < 32; k++) begin
            step((k <= 2 || k == 8) ? 10'h004 : 10'h000);
            exp_upd = (k % 8 == 0) && (k <= 24);
            exp_pa  = (k >= 1) && (k <= 23);
            if (updates_out[2]) pulses++;
            n_compared++;
            if (updates_out !== (NE'(exp_upd) << 2) || pending_any !== exp_pa) begin
                n_mismatched++;
                $display("FAIL emit_edge_event k=%0d: got upd=%h pa=%b expected upd=%h pa=%b",
                         k, updates_out, pending_any, NE'(exp_upd) << 2, exp_pa);
            end
        end
        n_compared++;
        if (pulses != 4) begin
            n_mismatched++;
            $display("FAIL emit_edge_event_count: got %0d expected 4", pulses);
        end
    endtask

    task automatic test_all_lines();
        step(10'h3FF);
        n_compared++;
        if (updates_out !== 10'h3FF || pending_any !== 1'b0) begin
            n_mismatched++;
            $display("FAIL all_lines_pulse: got upd=%h pa=%b expected upd=3ff pa=0",
                     updates_out, pending_any);
        end
        step(10'h000);
        n_compared++;
        if (updates_out !== 10'h000) begin
            n_mismatched++;
            $display("FAIL all_lines_after: got %h expected %h", updates_out, 10'h000);
        end
        repeat (8) step(10'h000);
    endtask

    // Bit 5 events at k=0..4: pend=4, then the k=8 emit leaves pend=3 with
    // updates_out[5] high. Reset mid-cycle must clear everything at once.
    task automatic test_async_reset();
        for (int k = 0; k < 9; k++) begin
            step((k < 5) ? 10'h020 : 10'h000);
        end
        n_compared++;
        if (updates_out !== 10'h020 || pending_any !== 1'b1) begin
            n_mismatched++;
            $display("FAIL async_reset_setup: got upd=%h pa=%b expected upd=020 pa=1",
                     updates_out, pending_any);
        end
        #2;
        reset = 1'b0;
        #1;
        n_compared++;
        if (updates_out !== '0 || overflow !== '0 || pending_any !== 1'b0) begin
            n_mismatched++;
            $display("FAIL async_reset_immediate: got upd=%h ovf=%h pa=%b expected upd=000 ovf=000 pa=0",
                     updates_out, overflow, pending_any);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step(10'h000);
            n_compared++;
            if (updates_out !== '0 || pending_any !== 1'b0) begin
                n_mismatched++;
                $display("FAIL async_reset_quiet k=%0d: got upd=%h pa=%b expected upd=000 pa=0",
                         k, updates_out, pending_any);
            end
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b0;
        events_in    = '0;
        overflow_clr = 1'b0;
        test_reset();
        test_single_pulse();
        test_back_to_back();
        test_saturation();
        test_emit_edge_event();
        test_all_lines();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_router_op_lut_event_pacer
`default_nettype wire
